// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU) for the HI/LO path: one trial-subtract-and-shift step per cycle.
// Optional: define MIPS_DIV_EARLY_OUT_EN to skip the iterations when divisor==0 or |dividend| < |divisor|.
module mips_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] prem_q, prem_d;       // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;         // shifting dividend, becomes quotient magnitude
    logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
    logic [WIDTH-1:0] orig_q, orig_d;       // unmodified dividend for the divide-by-zero result
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   shifted, diff;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor : divisor;
    assign shifted = {prem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prem_d      = prem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        orig_d      = orig_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    orig_d  = dividend;
                    dvd_d   = dvd_abs;
                    dvs_d   = dvs_abs;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    zero_d  = (divisor == '0);
                    prem_d  = '0;
                    count_d = CW'(WIDTH - 1);
                    dbz_d   = 1'b0;
                    state_d = RUN;
`ifdef MIPS_DIV_EARLY_OUT_EN
                    if (divisor == '0 || dvd_abs < dvs_abs) begin
                        prem_d  = dvd_abs;
                        dvd_d   = '0;
                        state_d = FIX;
                    end
`else
`endif
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    prem_d = diff[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == '0) state_d = FIX;
                else               count_d = count_q - CW'(1);
            end
            FIX: begin
                // Modulo negation makes most-negative / -1 come out as most-negative with no special case.
                quotient_d  = q_neg_q ? -dvd_q : dvd_q;
                remainder_d = r_neg_q ? -prem_q : prem_q;
                dbz_d       = zero_q;
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = orig_q;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath scratch registers are
    // deliberately left out of reset because IDLE reloads them before they are ever read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        prem_q  <= prem_d;
        dvd_q   <= dvd_d;
        dvs_q   <= dvs_d;
        orig_q  <= orig_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
        zero_q  <= zero_d;
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed self-checking bench for mips_seq_divider (WIDTH=32); cycle 0 is the start-accept cycle.
module tb_mips_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

`ifdef MIPS_DIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 34;
`endif

    mips_seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents a start in cycle 0 and returns in cycle 1 with start dropped.
    task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        cyc       = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int lim;
        lim = cyc + 100;
        while (done !== 1'b1 && cyc < lim) step();
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eq, input logic [31:0] er, input logic ez);
        do_start(sgn, a, b);
        check({tag, " busy@1"}, {31'd0, busy}, 32'd1);
        wait_done();
        check({tag, " done_cycle"}, cyc, lat);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
        step();
        check({tag, " done_drop"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        step();
        step();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("u100/7",  1'b0, 32'd100,       32'd7,          34, 32'd14,        32'd2,         1'b0);
        run_op("s-7/2",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002,  34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s7/-2",   1'b1, 32'h0000_0007, 32'hFFFF_FFFE,  34, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run_op("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  34, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op("u_max/1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001,  34, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("s_dbz",   1'b1, 32'h0000_1234, 32'h0000_0000,  ZERO_LAT, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_op("u_dbz",   1'b0, 32'h0000_1234, 32'h0000_0000,  ZERO_LAT, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

        // Starts in cycles 5 and 34 must be ignored; the one in cycle 35 is accepted.
        do_start(1'b0, 32'd100, 32'd7);
        check("dbz cleared on start", {31'd0, div_by_zero}, 32'd0);
        while (cyc < 5) step();
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        step();
        start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        wait_done();
        check("ign done_cycle", cyc, 34);
        check("ign quotient", quotient, 32'd14);
        check("ign remainder", remainder, 32'd2);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        step();
        check("ign idle@35", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        check("9/3 busy@36", {31'd0, busy}, 32'd1);
        wait_done();
        check("9/3 done_cycle", cyc, 69);
        check("9/3 quotient", quotient, 32'd3);
        check("9/3 remainder", remainder, 32'd0);
        step();

        // Reset in cycle 12 discards the partial result and clears the outputs.
        do_start(1'b0, 32'd1000, 32'd10);
        while (cyc < 12) step();
        rst_n = 1'b0;
        step();
        check("mid_rst busy", {31'd0, busy}, 32'd0);
        check("mid_rst done", {31'd0, done}, 32'd0);
        check("mid_rst quotient", quotient, 32'd0);
        check("mid_rst remainder", remainder, 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check("mid_rst no_done", done_seen, 0);
        run_op("u50/5", 1'b0, 32'd50, 32'd5, 34, 32'd10, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_seq_divider.md
Name: mips_seq_divider

Overview:
- Multi-cycle restoring divider for the MIPS EX stage; performs DIV/DIVU for the HI/LO path.
- Inverse of the datapath's add/subtract bit cells: one trial-subtract-and-shift step per cycle.
- Pipeline control stalls on busy and writes quotient to LO and remainder to HI on done.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 4)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
start  input  1  request a divide; accepted only when busy=0
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  result to LO
remainder  output  WIDTH  result to HI
div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- One clock, reset is synchronous and active-low. rst_n=0 at any edge, including mid-operation: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. A partial result is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 captures operands into internal registers. Signed mode stores absolute values, the quotient sign (dividend[MSB] XOR divisor[MSB]) and the remainder sign (dividend[MSB]). Counter loads WIDTH-1, partial remainder clears to 0, next state is RUN.
- RUN: each cycle, shift {partial_rem, dividend_reg} left by 1.
  - Trial-subtract divisor from the (WIDTH+1)-bit partial remainder. If non-negative, keep the difference and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - Stays WIDTH cycles; on counter=0, next state is FIX.
- FIX: in signed mode, negate the quotient if its sign flag is set and negate the remainder if its sign flag is set. All negation is modulo 2^WIDTH.
  - Divisor==0: quotient forced to all ones, remainder forced to the original unmodified dividend, div_by_zero=1.
  - Next state is DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- busy=1 in RUN, FIX and DONE; busy=0 only in IDLE.
- Latency: counting the start-accept cycle as cycle 0, busy rises in cycle 1 and done is high in cycle WIDTH+2. The next start is accepted in cycle WIDTH+3 at the earliest.
- start while busy=1, including in the DONE cycle: ignored; captured operands are unaffected.
- quotient/remainder/div_by_zero are registered. They update only on the FIX→DONE edge and hold until the next FIX→DONE edge.
- div_by_zero clears when the next start is accepted.
- Signed overflow (most-negative / -1): quotient = most-negative value (0x80000000 for WIDTH=32), remainder = 0, div_by_zero=0. This falls out of the modulo negation.
- Remainder magnitude is always < |divisor|. Remainder sign follows the dividend (truncating division, MIPS semantics).

Optional Feature:
- Macro: MIPS_DIV_EARLY_OUT_EN.
- Defined: in IDLE on an accepted start, if divisor==0 or |dividend| < |divisor| (unsigned compare of magnitudes), skip RUN and go directly to FIX.
  - Quotient is 0, or all ones for divisor==0; remainder is the original dividend.
  - done is high in cycle 2.
- Not defined: every operation takes the full WIDTH+2 latency; the results are identical either way.

Test Plan:
- Unsigned 100/7 (is_signed=0), start in cycle 0 -> busy=1 in cycle 1; done=1 in cycle 34 only; quotient=14, remainder=2, div_by_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7/-2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0. Unsigned 0xFFFFFFFF / 0x00000001 -> quotient=0xFFFFFFFF, remainder=0.
- 0x00001234/0 (both modes) -> quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1. Done in cycle 34, or cycle 2 with MIPS_DIV_EARLY_OUT_EN; div_by_zero clears on the next accepted start.
- Start 100/7, pulse start with 9/3 in cycles 5 and 34 -> both ignored; result 14/2. Start 9/3 in cycle 35 -> accepted; quotient=3, remainder=0 in cycle 69.
- Start 1000/10, drive rst_n=0 in cycle 12 -> after that edge busy=0, done=0, quotient=0, remainder=0. No done pulse follows; a new start 50/5 after release gives quotient=10, remainder=0.
